// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants for the SHA-256 padder
package sha256_pkg;

    localparam logic [1:0] S_FILL = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_EMIT = 2'b10;

    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_len_mux.sv
// rtl/sha256_len_mux.sv - picks one big-endian byte of the 64-bit bit length
module sha256_len_mux (
    input  logic [63:0] bit_len,
    input  logic [2:0]  sel,
    output logic [7:0]  len_byte
);

    // sel 0 is the most significant byte, so the bit offset is (7 - sel) * 8
    logic [5:0] lsb;
    assign lsb      = {~sel, 3'b000};
    assign len_byte = bit_len[lsb +: 8];

endmodule

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - byte-stream to padded 512-bit block burst converter
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 61
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       core_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       first_block,
    output logic       last_block,
    output logic       busy
);

    logic [1:0]       state;
    logic [6:0]       fill_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [5:0]       idx;
    logic             msg_done;
    logic             marker_done;
    logic             first_pend;
    logic             final_q;
    logic [7:0]       blk_buf [BLOCK_BYTES];

    logic        accept;
    logic        emitting;
    logic        last_idx;
    logic        final_now;
    logic        marker_here;
    logic [7:0]  need;
    logic [63:0] bit_len;
    logic [7:0]  len_byte;

    assign emitting = (state == S_EMIT);
    assign in_ready = (state == S_FILL) && !msg_done && (fill_cnt < 7'(BLOCK_BYTES));
    assign accept   = in_valid && in_ready;
    assign last_idx = (idx == 6'(BLOCK_BYTES - 1));

    // A block is the final one when the marker (if still owed) and the length both fit
    assign need        = {1'b0, fill_cnt} + {7'd0, ~marker_done};
    assign final_now   = msg_done && (need <= 8'(LEN_OFFSET));
    assign marker_here = msg_done && !marker_done && (fill_cnt < 7'(BLOCK_BYTES));

    assign bit_len = 64'(byte_cnt) << 3;

    sha256_len_mux u_len_mux (
        .bit_len  (bit_len),
        .sel      (idx[2:0]),
        .len_byte (len_byte)
    );

    assign out_valid   = emitting;
    assign first_block = emitting && (idx == 6'd0) && first_pend;
    assign last_block  = emitting && (idx == 6'd0) && final_q;
    assign busy        = (state != S_FILL) || (fill_cnt != 7'd0);

    // Block byte selection: buffered data, then marker, then zeros/length
    always_comb begin
        out_data = 8'h00;
        if (emitting) begin
            if ({1'b0, idx} < fill_cnt) begin
                out_data = blk_buf[idx];
            end else if (({1'b0, idx} == fill_cnt) && !marker_done) begin
                out_data = PAD_BYTE;
            end else if (final_q && (idx >= 6'(LEN_OFFSET))) begin
                out_data = len_byte;
            end
        end
    end

    // Block buffer write; contents need no reset since fill_cnt gates every read
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_buf[fill_cnt[5:0]] <= in_data;
        end
    end

    // Fill / wait / emit sequencing and message bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            fill_cnt    <= 7'd0;
            byte_cnt    <= '0;
            idx         <= 6'd0;
            msg_done    <= 1'b0;
            marker_done <= 1'b0;
            first_pend  <= 1'b1;
            final_q     <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + 7'd1;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        if (in_last) begin
                            msg_done <= 1'b1;
                        end
                        if (in_last || (fill_cnt == 7'(BLOCK_BYTES - 1))) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_ready) begin
                        state   <= S_EMIT;
                        idx     <= 6'd0;
                        final_q <= final_now;
                    end
                end
                S_EMIT: begin
                    idx <= idx + 6'd1;
                    if (idx == 6'd0) begin
                        first_pend <= 1'b0;
                    end
                    if (last_idx) begin
                        fill_cnt <= 7'd0;
                        if (marker_here) begin
                            marker_done <= 1'b1;
                        end
                        if (final_q) begin
                            msg_done    <= 1'b0;
                            marker_done <= 1'b0;
                            byte_cnt    <= '0;
                            first_pend  <= 1'b1;
                            state       <= S_FILL;
                        end else if (msg_done) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed vector bench for sha256_padder
module tb_sha256_padder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       core_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       first_block;
    logic       last_block;
    logic       busy;

    sha256_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .core_ready  (core_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .first_block (first_block),
        .last_block  (last_block),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [7:0]  base;
        logic [7:0]  step;
        int          nblk;
        logic [63:0] bitlen;
    } vec_t;

    vec_t vecs[6];

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] cap_data[$];
    logic       cap_first[$];
    logic       cap_last[$];
    int         runs[$];
    int         run_len = 0;

    logic [7:0] exp_data[$];
    logic       exp_first[$];
    logic       exp_last[$];

    always @(negedge clk) begin
        if (out_valid) begin
            cap_data.push_back(out_data);
            cap_first.push_back(first_block);
            cap_last.push_back(last_block);
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_all();
        cap_data.delete(); cap_first.delete(); cap_last.delete(); runs.delete();
        exp_data.delete(); exp_first.delete(); exp_last.delete();
    endtask

    task automatic add_expected(vec_t v);
        int total;
        logic [7:0] b;
        total = v.nblk * 64;
        for (int p = 0; p < total; p++) begin
            if (p < v.len) b = v.base + 8'(p) * v.step;
            else if (p == v.len) b = 8'h80;
            else if (p >= total - 8) b = v.bitlen[8*(total-1-p) +: 8];
            else b = 8'h00;
            exp_data.push_back(b);
        end
        for (int k = 0; k < v.nblk; k++) begin
            exp_first.push_back(k == 0);
            exp_last.push_back(k == v.nblk - 1);
        end
    endtask

    task automatic send_byte(logic [7:0] d, logic l);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_msg(vec_t v);
        for (int i = 0; i < v.len; i++)
            send_byte(v.base + 8'(i) * v.step, i == v.len - 1);
    endtask

    task automatic wait_bytes(int n);
        int t;
        t = 0;
        while (cap_data.size() < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (cap_data.size() < n) begin
            n_total++;
            $display("FAIL burst timeout: got %0d bytes expected %0d", cap_data.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_bursts(string name);
        int nb;
        int bad;
        logic [1:0] fpat, lpat;
        check({name, " byte count"}, 64'(cap_data.size()), 64'(exp_data.size()));
        check({name, " burst count"}, 64'(runs.size()), 64'(exp_first.size()));
        if (cap_data.size() == exp_data.size() && runs.size() == exp_first.size()) begin
            nb = exp_first.size();
            for (int b = 0; b < nb; b++) begin
                bad = 0;
                fpat = 2'b00;
                lpat = 2'b00;
                for (int i = 0; i < 64; i++) begin
                    if (cap_data[b*64+i] !== exp_data[b*64+i]) bad++;
                    if (i == 0) begin
                        fpat[1] = cap_first[b*64];
                        lpat[1] = cap_last[b*64];
                    end else begin
                        fpat[0] = fpat[0] | cap_first[b*64+i];
                        lpat[0] = lpat[0] | cap_last[b*64+i];
                    end
                end
                check($sformatf("%s blk%0d bad bytes", name, b), 64'(bad), 64'd0);
                check($sformatf("%s blk%0d first_block", name, b), 64'(fpat), {62'd0, exp_first[b], 1'b0});
                check($sformatf("%s blk%0d last_block", name, b), 64'(lpat), {62'd0, exp_last[b], 1'b0});
                check($sformatf("%s blk%0d run length", name, b), 64'(runs[b]), 64'd64);
            end
        end
    endtask

    task automatic run_vec(string name, vec_t v);
        clear_all();
        add_expected(v);
        send_msg(v);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_bytes(exp_data.size());
        check_bursts(name);
        check({name, " idle busy/in_ready"}, {62'd0, busy, in_ready}, 64'b01);
    endtask

    initial begin
        int ov_seen;
        int ir_seen;
        int t;
        vec_t full64;

        vecs[0] = '{3,   8'h61, 8'h01, 1, 64'h18};
        vecs[1] = '{56,  8'hAA, 8'h00, 2, 64'h1C0};
        vecs[2] = '{64,  8'h00, 8'h01, 2, 64'h200};
        vecs[3] = '{55,  8'h11, 8'h03, 1, 64'h1B8};
        vecs[4] = '{63,  8'hF0, 8'h01, 2, 64'h1F8};
        vecs[5] = '{120, 8'h05, 8'h07, 3, 64'h3C0};

        reset      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        core_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", {out_data, in_ready, out_valid, first_block, last_block, busy},
              {8'h00, 5'b10000});
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Minimum latency: out_valid two cycles after the last byte handshake
        clear_all();
        add_expected(vecs[0]);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("latency cycle1", {62'd0, out_valid, in_ready}, 64'b00);
        @(negedge clk);
        check("latency cycle2", {61'd0, out_valid, first_block, last_block}, 64'b111);
        wait_bytes(64);
        check_bursts("latency");

        // Core stall: nothing emitted until core_ready rises
        core_ready = 1'b0;
        clear_all();
        add_expected(vecs[0]);
        send_msg(vecs[0]);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ov_seen = 0;
        ir_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (in_ready) ir_seen++;
        end
        check("stall out_valid", 64'(ov_seen), 64'd0);
        check("stall in_ready", 64'(ir_seen), 64'd0);
        core_ready = 1'b1;
        @(negedge clk);
        check("stall start", {63'd0, out_valid}, 64'd1);
        wait_bytes(64);
        check_bursts("stall");

        // Reset in the middle of a burst
        clear_all();
        full64 = vecs[2];
        send_msg(full64);
        in_valid = 1'b0;
        in_last  = 1'b0;
        t = 0;
        while (cap_data.size() < 31 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reach idx30", 64'(cap_data.size()), 64'd31);
        reset = 1'b0;
        #1;
        check("midburst reset outputs", {out_data, in_ready, out_valid, first_block, last_block, busy},
              {8'h00, 5'b10000});
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_vec("after reset", vecs[0]);

        // Back-to-back messages with in_valid held high
        clear_all();
        add_expected(vecs[0]);
        add_expected(vecs[0]);
        send_msg(vecs[0]);
        check("b2b in_ready after last", {63'd0, in_ready}, 64'd0);
        send_msg(vecs[0]);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_bytes(128);
        check_bursts("b2b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream stage of the SHA-256 core: accepts the raw message as a byte stream with a valid/ready handshake.
- Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length.
- Emits 512-bit blocks as 64-cycle byte bursts with first_block/last_block strobes that drive the core controller.
- Holds one block in a 64-byte buffer so input stalls never fragment an output burst.

Parameters:
- LEN_W, 61, width of the message byte counter; bit length = byte count << 3, zero-extended to 64 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  message byte
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the final byte of the message (valid with in_valid)
- in_ready  out  1  padder accepts a byte this cycle
- core_ready  in  1  core can take a new block; sampled only in S_WAIT
- out_data  out  8  block byte, index 0 first
- out_valid  out  1  high on all 64 burst cycles
- first_block  out  1  high on burst cycle 0 of a message's first block
- last_block  out  1  high on burst cycle 0 of a message's final (length-bearing) block
- busy  out  1  high whenever the state is not S_FILL or fill_cnt != 0

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally) forces:
  - state=S_FILL; fill_cnt=0, byte_cnt=0, idx=0.
  - msg_done=0, marker_done=0, first_pend=1.
  - Outputs: in_ready=1, out_valid=0, out_data=0, first_block=0, last_block=0, busy=0.
  - Reset mid-burst aborts the burst immediately; no partial-block recovery.
- S_FILL:
  - in_ready = !msg_done && fill_cnt<64.
  - Each handshake writes buf[fill_cnt], then fill_cnt+1 and byte_cnt+1 (byte_cnt wraps modulo 2^LEN_W).
  - Accepted in_last sets msg_done.
  - Go to S_WAIT when fill_cnt reaches 64, or on the cycle after msg_done is set.
- S_WAIT:
  - in_ready=0.
  - When core_ready=1, go to S_EMIT with idx=0. Minimum latency from the accepted 64th/last byte to the first out_valid is 2 cycles.
- S_EMIT: idx 0..63, one byte per cycle, no stall. out_data[idx] is:
  - buf[idx] if idx<fill_cnt;
  - else 0x80 if idx==fill_cnt and !marker_done;
  - else, if final=1 and idx>=56, byte (idx-56) of the 64-bit big-endian bit length;
  - else 0x00.
- final flag: final = msg_done && (fill_cnt + (marker_done?0:1) <= 56). It is evaluated once at burst start and held.
- End of burst (idx==63):
  - If the marker was placed in this block, set marker_done=1. fill_cnt=0.
  - If final: clear msg_done, marker_done and byte_cnt, set first_pend=1, go to S_FILL.
  - Else if msg_done (padding overflow block needed): go directly to S_WAIT.
  - Else go to S_FILL.
- first_block = out_valid && idx==0 && first_pend. first_pend clears after that cycle.
- last_block = out_valid && idx==0 && final.
- Both strobes are high together for single-block messages.
- Boundaries:
  - fill_cnt 56..63 at message end: marker goes in this block; a separate all-zero+length block follows.
  - Message ending on a full 64-byte block: the next block carries 0x80 at idx 0, zeros, and the length.
  - in_valid while in_ready=0: the byte is held by the source, never dropped.
  - Zero-length messages are unsupported: in_last must accompany a real byte.
  - in_last without in_valid is ignored.

Decomposition:
- Shared package sha256_pkg holds:
  - state encodings S_FILL=2'b00, S_WAIT=2'b01, S_EMIT=2'b10;
  - BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80.
- One natural sub-module: sha256_len_mux. It is combinational and selects the length byte for a given idx from a 64-bit bit length.
- The buffer, counters and FSM stay in sha256_padder.

Test Plan:
- "abc" (61 62 63, in_last on 63), core_ready=1 -> one burst:
  - bytes 61 62 63 80, zeros, bytes 56..63 = 00 00 00 00 00 00 00 18;
  - first_block=last_block=1 on cycle 0.
- 56-byte message of 0xAA -> two bursts:
  - burst 1: 56×AA, 80, 7×00, first_block only;
  - burst 2: 56×00 then 00 00 00 00 00 00 01 C0, last_block only.
- 64-byte message -> burst 1 is 64 data bytes. Burst 2 is 80, 55×00, then 00 00 00 00 00 00 02 00, with last_block=1.
- Hold core_ready=0 for 20 cycles after the "abc" in_last -> no out_valid, in_ready=0; the burst starts 1 cycle after core_ready rises and is identical to scenario 1.
- Assert reset at burst idx 30 of scenario 3 -> all outputs 0 the same cycle. A following "abc" produces the scenario-1 output exactly, with first_block=1.
- Two back-to-back "abc" messages with in_valid held high -> the second message waits (in_ready=0) until the first burst ends; each burst has first_block=last_block=1.
